// File: rtl/shift_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality for the shift/rotate unit.
// Rotate opcodes count as legal only when SHIFT_UNIT_ROTATE_EN is defined.
package shift_pkg;

   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic is_legal_op(input logic [4:0] op);
      logic legal;
      case (op)
         OP_SHR, OP_SHL, OP_SHRA: legal = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
         OP_ROR, OP_ROL:          legal = 1'b1;
`endif
         default:                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by n (0..STEP) positions and reports the last bit out.
// Rotate paths are built only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   localparam int AMTW = $clog2(WIDTH),
   localparam int NW   = $clog2(STEP) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [4:0]       op_i,
   input  logic [NW-1:0]    n_i,
   output logic [WIDTH-1:0] data_o,
   output logic             carry_o
);

   logic [AMTW-1:0] n_s;
   logic [AMTW-1:0] r_idx_s;
   logic [AMTW-1:0] l_idx_s;

   // Right shifts lose bit n-1 last; left shifts lose bit WIDTH-n last (mod-2^AMTW arithmetic).
   assign n_s     = AMTW'(n_i);
   assign r_idx_s = n_s - AMTW'(1);
   assign l_idx_s = AMTW'(WIDTH) - n_s;

   always_comb begin
      data_o  = data_i;
      carry_o = 1'b0;
      if (n_s != '0) begin
         case (op_i)
            OP_SHR: begin
               data_o  = data_i >> n_s;
               carry_o = data_i[r_idx_s];
            end
            OP_SHL: begin
               data_o  = data_i << n_s;
               carry_o = data_i[l_idx_s];
            end
            OP_SHRA: begin
               data_o  = $signed(data_i) >>> n_s;
               carry_o = data_i[r_idx_s];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR: begin
               data_o  = (data_i >> n_s) | (data_i << l_idx_s);
               carry_o = data_i[r_idx_s];
            end
            OP_ROL: begin
               data_o  = (data_i << n_s) | (data_i >> l_idx_s);
               carry_o = data_i[l_idx_s];
            end
`endif
            default: begin
               data_o  = data_i;
               carry_o = 1'b0;
            end
         endcase
      end else begin
         data_o  = data_i;
         carry_o = 1'b0;
      end
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake, STEP positions per clock.
// Optional rotate support is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   localparam int AMTW = $clog2(WIDTH),
   localparam int NW   = $clog2(STEP) + 1
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             err
);

   state_e           state_q,  state_d;
   logic [4:0]       op_q,     op_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [AMTW-1:0]  rem_q,    rem_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q,  carry_d;
   logic             err_q,    err_d;

   logic [AMTW-1:0]  amt_s;
   logic [AMTW-1:0]  rem_next_s;
   logic [NW-1:0]    n_s;
   logic [WIDTH-1:0] step_data_s;
   logic             step_carry_s;
   logic             legal_s;
   logic             amount_unused_s;

   assign amt_s           = amount[AMTW-1:0];
   assign amount_unused_s = ^amount[WIDTH-1:AMTW];
   assign legal_s         = is_legal_op(op);

   // Step size this cycle: the full STEP unless fewer positions remain.
   assign n_s        = (rem_q < AMTW'(STEP)) ? NW'(rem_q) : NW'(STEP);
   assign rem_next_s = rem_q - AMTW'(n_s);

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .data_i  (work_q),
      .op_i    (op_q),
      .n_i     (n_s),
      .data_o  (step_data_s),
      .carry_o (step_carry_s)
   );

   // Next-state logic: accept in IDLE/DONE, iterate in RUN, publish result on entry to DONE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      rem_d    = rem_q;
      result_d = result_q;
      carry_d  = carry_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               op_d    = op;
               work_d  = operand;
               carry_d = 1'b0;
               err_d   = 1'b0;
               if ((amt_s == '0) || !legal_s) begin
                  state_d  = ST_DONE;
                  result_d = operand;
                  err_d    = !legal_s;
               end else begin
                  state_d = ST_RUN;
                  rem_d   = amt_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            work_d  = step_data_s;
            carry_d = step_carry_s;
            rem_d   = rem_next_s;
            if (rem_next_s == '0) begin
               state_d  = ST_DONE;
               result_d = step_data_s;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous Clear.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q  <= ST_IDLE;
         op_q     <= 5'b00000;
         work_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign carry  = carry_q;
   assign err    = err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: a STEP=1 instance and a STEP=4 instance share stimulus.
// Rotate expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

   localparam logic [4:0] SHR  = 5'b00100;
   localparam logic [4:0] SHL  = 5'b00101;
   localparam logic [4:0] SHRA = 5'b00110;
   localparam logic [4:0] ROL  = 5'b01000;
   localparam logic [4:0] BAD  = 5'b11111;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  op = 5'b00000;
   logic [31:0] operand = 32'h0;
   logic [31:0] amount = 32'h0;

   logic        busy1, done1, carry1, err1;
   logic [31:0] result1;
   logic        busy4, done4, carry4, err4;
   logic [31:0] result4;

   int vectors = 0;
   int fails = 0;

   int          w1, w4, bcnt;
   logic [31:0] r1, r4;
   logic        c1, c4, e1, e4;

   always #5 clk = ~clk;

   shift_unit #(.WIDTH(32), .STEP(1)) dut (
      .Clock(clk), .Clear(clr), .start(start), .op(op), .operand(operand), .amount(amount),
      .busy(busy1), .done(done1), .result(result1), .carry(carry1), .err(err1)
   );

   shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
      .Clock(clk), .Clear(clr), .start(start), .op(op), .operand(operand), .amount(amount),
      .busy(busy4), .done(done4), .result(result4), .carry(carry4), .err(err4)
   );

   // Issue one op to both instances; record edges-after-acceptance until each done and its outputs.
   task automatic run_op(input logic [4:0] o, input logic [31:0] d, input logic [31:0] a);
      int edges;
      @(negedge clk);
      start = 1'b1; op = o; operand = d; amount = a;
      @(negedge clk);
      start = 1'b0;
      w1 = -1; w4 = -1; bcnt = 0; edges = 0;
      while ((w1 < 0 || w4 < 0) && edges < 100) begin
         if (busy1 && w1 < 0) bcnt++;
         if (done1 && w1 < 0) begin w1 = edges; r1 = result1; c1 = carry1; e1 = err1; end
         if (done4 && w4 < 0) begin w4 = edges; r4 = result4; c4 = carry4; e4 = err4; end
         if (w1 < 0 || w4 < 0) begin
            @(negedge clk);
            edges++;
         end
      end
      if (w1 < 0 || w4 < 0) begin
         vectors++; fails++;
         $display("FAIL timeout: done1 seen=%0d done4 seen=%0d, required both", w1, w4);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy1, done1, carry1, err1, result1} !== 36'h0) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b carry=%b err=%b result=%h, required all 0",
                  busy1, done1, carry1, err1, result1);
      end
      clr = 1'b0;
   endtask

   task automatic test_shl();
      run_op(SHL, 32'h00000022, 32'd5);
      vectors++;
      if (r1 !== 32'h00000440 || c1 !== 1'b0 || e1 !== 1'b0) begin
         fails++; $display("FAIL shl5: result=%h carry=%b err=%b, required 00000440 0 0", r1, c1, e1);
      end
      vectors++;
      if (w1 !== 5 || bcnt !== 5) begin
         fails++; $display("FAIL shl5_timing: done after %0d edges busy %0d, required 5 5", w1, bcnt);
      end
      run_op(SHL, 32'h00000003, 32'd31);
      vectors++;
      if (r1 !== 32'h80000000 || c1 !== 1'b1 || w1 !== 31) begin
         fails++; $display("FAIL shl31: result=%h carry=%b edges=%0d, required 80000000 1 31", r1, c1, w1);
      end
   endtask

   task automatic test_shr_shra();
      run_op(SHRA, 32'h80000000, 32'd4);
      vectors++;
      if (r1 !== 32'hF8000000 || c1 !== 1'b0 || w1 !== 4) begin
         fails++; $display("FAIL shra4: result=%h carry=%b edges=%0d, required f8000000 0 4", r1, c1, w1);
      end
      run_op(SHR, 32'h80000000, 32'd4);
      vectors++;
      if (r1 !== 32'h08000000 || c1 !== 1'b0) begin
         fails++; $display("FAIL shr4: result=%h carry=%b, required 08000000 0", r1, c1);
      end
      run_op(SHR, 32'h00000005, 32'd1);
      vectors++;
      if (r1 !== 32'h00000002 || c1 !== 1'b1) begin
         fails++; $display("FAIL shr1_carry: result=%h carry=%b, required 00000002 1", r1, c1);
      end
   endtask

   task automatic test_step4();
      run_op(SHR, 32'hFFFFFFFF, 32'h0000003F);
      vectors++;
      if (r4 !== 32'h00000001 || c4 !== 1'b1 || w4 !== 8) begin
         fails++; $display("FAIL step4_shr31: result=%h carry=%b edges=%0d, required 00000001 1 8", r4, c4, w4);
      end
      vectors++;
      if (r1 !== 32'h00000001 || c1 !== 1'b1 || w1 !== 31) begin
         fails++; $display("FAIL step1_shr31: result=%h carry=%b edges=%0d, required 00000001 1 31", r1, c1, w1);
      end
   endtask

   task automatic test_rotate();
      run_op(ROL, 32'h80000001, 32'd1);
      vectors++;
`ifdef SHIFT_UNIT_ROTATE_EN
      if (r1 !== 32'h00000003 || c1 !== 1'b1 || e1 !== 1'b0 || w1 !== 1) begin
         fails++; $display("FAIL rol1: result=%h carry=%b err=%b edges=%0d, required 00000003 1 0 1", r1, c1, e1, w1);
      end
`else
      if (r1 !== 32'h80000001 || c1 !== 1'b0 || e1 !== 1'b1 || w1 !== 0) begin
         fails++; $display("FAIL rol1_off: result=%h carry=%b err=%b edges=%0d, required 80000001 0 1 0", r1, c1, e1, w1);
      end
`endif
   endtask

   task automatic test_zero_and_illegal();
      run_op(SHL, 32'hDEADBEEF, 32'hFFFFFFE0);
      vectors++;
      if (r1 !== 32'hDEADBEEF || e1 !== 1'b0 || c1 !== 1'b0 || w1 !== 0) begin
         fails++; $display("FAIL amt0: result=%h err=%b carry=%b edges=%0d, required deadbeef 0 0 0", r1, e1, c1, w1);
      end
      run_op(BAD, 32'h12345678, 32'd3);
      vectors++;
      if (r1 !== 32'h12345678 || e1 !== 1'b1 || c1 !== 1'b0 || w1 !== 0) begin
         fails++; $display("FAIL badop: result=%h err=%b carry=%b edges=%0d, required 12345678 1 0 0", r1, e1, c1, w1);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b0 || err1 !== 1'b1) begin
         fails++; $display("FAIL done_pulse: done=%b err=%b, required 0 1", done1, err1);
      end
   endtask

   task automatic test_back_to_back();
      run_op(SHL, 32'h00000001, 32'd1);
      start = 1'b1; op = SHR; operand = 32'h00001234; amount = 32'd0;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (done1 !== 1'b1 || result1 !== 32'h00001234 || err1 !== 1'b0) begin
         fails++; $display("FAIL b2b: done=%b result=%h err=%b, required 1 00001234 0", done1, result1, err1);
      end
      @(negedge clk);
      vectors++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         fails++; $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done1, busy1);
      end
   endtask

   task automatic test_clear();
      int seen;
      @(negedge clk);
      start = 1'b1; op = SHL; operand = 32'h00000001; amount = 32'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      vectors++;
      if ({busy1, done1, carry1, err1, result1} !== 36'h0) begin
         fails++; $display("FAIL clear_run: busy=%b done=%b carry=%b err=%b result=%h, required all 0",
                           busy1, done1, carry1, err1, result1);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done1 || busy1) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         fails++; $display("FAIL clear_discard: %0d cycles busy/done, required 0", seen);
      end
      clr = 1'b1; start = 1'b1; op = SHL; operand = 32'h00000001; amount = 32'd1;
      @(negedge clk);
      clr = 1'b0; start = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         fails++; $display("FAIL clear_start: busy=%b done=%b, required 0 0", busy1, done1);
      end
   endtask

   task automatic test_start_in_run();
      int edges;
      @(negedge clk);
      start = 1'b1; op = SHL; operand = 32'h00000001; amount = 32'd2;
      @(negedge clk);
      start = 1'b1; op = SHL; operand = 32'h000000FF; amount = 32'd7;
      @(negedge clk);
      start = 1'b0;
      edges = 1;
      while (!done1 && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      vectors++;
      if (done1 !== 1'b1 || edges !== 2 || result1 !== 32'h00000004 || carry1 !== 1'b0) begin
         fails++; $display("FAIL start_in_run: done=%b edges=%0d result=%h carry=%b, required 1 2 00000004 0",
                           done1, edges, result1, carry1);
      end
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         fails++; $display("FAIL start_in_run_idle: busy=%b done=%b, required 0 0", busy1, done1);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_shl();
      test_shr_shra();
      test_step4();
      test_rotate();
      test_zero_and_illegal();
      test_back_to_back();
      test_clear();
      test_start_in_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
